// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Control front-end for the 32-bit combinational ALU of the multi-cycle core.
// It takes an operation request from decode (ALUOp class, funct, operands),
// turns it into the 4-bit ALU opcode and holds operands/opcode on the ALU for
// one evaluation cycle. It then captures Result/Zero into an output register
// that writeback/branch logic reads through a valid/ready handshake.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   in_aluop, in_funct    main-control class and R-type funct field
//   in_a, in_b            operands
//   alu_a, alu_b, alu_op  registered drive to the ALU inputs
//   alu_result, alu_zero  ALU outputs, sampled at the end of EXEC
//   out_valid / out_ready result handshake
//   out_result, out_zero  captured ALU result and zero flag
//   out_illegal           request could not be decoded
//   op_count              count of completed (output-handshaked) operations
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [31:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    state_t           state_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic [3:0]       alu_op_reg;
    logic             illegal_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_result_reg;
    logic             out_zero_reg;
    logic             out_illegal_reg;
    logic [31:0]      op_count_reg;

    logic [3:0]       dec_op;
    logic             dec_illegal;
    logic             accept;
    logic             out_fire;

    // Opcode decode. Undecodable requests still present ADD on the bus so the
    // ALU sees a defined opcode; their result is discarded in EXEC.
    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        case (in_aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (in_funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    6'b100111: dec_op = OP_NOR;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // A new request can enter while the previous result leaves, so DONE with
    // out_ready behaves like IDLE for the input side.
    assign in_ready = ~rst & ((state_reg == IDLE) |
                              ((state_reg == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign out_fire = (state_reg == DONE) & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_op_reg      <= 4'b0000;
            illegal_reg     <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_result_reg  <= '0;
            out_zero_reg    <= 1'b0;
            out_illegal_reg <= 1'b0;
            op_count_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        alu_a_reg   <= in_a;
                        alu_b_reg   <= in_b;
                        alu_op_reg  <= dec_op;
                        illegal_reg <= dec_illegal;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    if (illegal_reg) begin
                        out_result_reg <= '0;
                        out_zero_reg   <= 1'b0;
                    end else begin
                        out_result_reg <= alu_result;
                        out_zero_reg   <= alu_zero;
                    end
                    out_illegal_reg <= illegal_reg;
                    out_valid_reg   <= 1'b1;
                    state_reg       <= DONE;
                end
                DONE: begin
                    if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        op_count_reg  <= op_count_reg + 32'd1;
                        if (in_valid) begin
                            alu_a_reg   <= in_a;
                            alu_b_reg   <= in_b;
                            alu_op_reg  <= dec_op;
                            illegal_reg <= dec_illegal;
                            state_reg   <= EXEC;
                        end else begin
                            // Park the ALU bus at a known value while idle.
                            alu_a_reg   <= '0;
                            alu_b_reg   <= '0;
                            alu_op_reg  <= 4'b0000;
                            illegal_reg <= 1'b0;
                            state_reg   <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_op      = alu_op_reg;
    assign out_valid   = out_valid_reg;
    assign out_result  = out_result_reg;
    assign out_zero    = out_zero_reg;
    assign out_illegal = out_illegal_reg;
    assign op_count    = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;
    logic [31:0] op_count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_count;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_aluop   (in_aluop),
        .in_funct   (in_funct),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_illegal(out_illegal),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Textbook combinational ALU driven by the sequencer's bus.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_op;
        logic [31:0] exp_result;
        logic        exp_zero;
        logic        exp_illegal;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Full single transaction from IDLE, checking exact cycle placement.
    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_vec(input vec_t v, input int idx);
        in_valid = 1'b1;
        in_aluop = v.aluop;
        in_funct = v.funct;
        in_a     = v.a;
        in_b     = v.b;
        out_ready = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);                     // EXEC cycle
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;           // must be ignored now
        in_b     = 32'hDEAD_BEEF;
        check("exec_alu_op", {28'd0, alu_op}, {28'd0, v.exp_op});
        check("exec_alu_a", alu_a, v.a);
        check("exec_alu_b", alu_b, v.b);
        check("exec_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);                     // DONE cycle
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
        check("done_result", out_result, v.exp_result);
        check("done_zero", {31'd0, out_zero}, {31'd0, v.exp_zero});
        check("done_illegal", {31'd0, out_illegal}, {31'd0, v.exp_illegal});
        check("done_in_ready_blocked", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("done_in_ready_open", {31'd0, in_ready}, 32'd1);
        $display("op %0d aluop=%b funct=%b a=0x%08h b=0x%08h -> op=%b result=0x%08h zero=%0b illegal=%0b",
                 idx, v.aluop, v.funct, v.a, v.b, alu_op, out_result, out_zero, out_illegal);
        @(negedge clk);                     // back in IDLE
        out_ready = 1'b0;
        exp_count = exp_count + 32'd1;
        check("post_op_count", op_count, exp_count);
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_idle_bus_op", {28'd0, alu_op}, 32'd0);
        check("post_idle_bus_a", alu_a, 32'd0);
    endtask

    initial begin
        logic [31:0] held;

        vecs[0]  = '{2'b10, 6'b100000, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0, 1'b0};
        vecs[1]  = '{2'b01, 6'b000000, 32'h1234_5678,  32'h1234_5678,  4'b0110, 32'd0,          1'b1, 1'b0};
        vecs[2]  = '{2'b10, 6'b101010, 32'hFFFF_FFFF,  32'd1,          4'b0111, 32'd1,          1'b0, 1'b0};
        vecs[3]  = '{2'b10, 6'b101010, 32'd1,          32'hFFFF_FFFF,  4'b0111, 32'd0,          1'b1, 1'b0};
        vecs[4]  = '{2'b10, 6'b000000, 32'd3,          32'd4,          4'b0010, 32'd0,          1'b0, 1'b1};
        vecs[5]  = '{2'b11, 6'b100000, 32'd3,          32'd4,          4'b0010, 32'd0,          1'b0, 1'b1};
        vecs[6]  = '{2'b00, 6'b000000, 32'd100,        32'd28,         4'b0010, 32'd128,        1'b0, 1'b0};
        vecs[7]  = '{2'b10, 6'b100100, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'b0000, 32'h00F0_00F0,  1'b0, 1'b0};
        vecs[8]  = '{2'b10, 6'b100101, 32'hF000_0000,  32'h0000_000F,  4'b0001, 32'hF000_000F,  1'b0, 1'b0};
        vecs[9]  = '{2'b10, 6'b100111, 32'd0,          32'd0,          4'b1100, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[10] = '{2'b10, 6'b100010, 32'd5,          32'd5,          4'b0110, 32'd0,          1'b1, 1'b0};
        vecs[11] = '{2'b10, 6'b101010, 32'd3,          32'd7,          4'b0111, 32'd1,          1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_aluop = 2'b00;
        in_funct = 6'd0;
        in_a = 32'd0;
        in_b = 32'd0;
        out_ready = 1'b0;
        exp_count = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_op_count", op_count, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure then back-to-back acceptance on the DONE handshake.
        in_valid = 1'b1; in_aluop = 2'b10; in_funct = 6'b100000;
        in_a = 32'd40; in_b = 32'd2;
        @(negedge clk);                     // EXEC
        in_valid = 1'b0;
        @(negedge clk);                     // DONE
        held = out_result;
        check("bp_first_result", held, 32'd42);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result_stable", out_result, 32'd42);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_op_count", op_count, exp_count);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_aluop = 2'b10; in_funct = 6'b100010;
        in_a = 32'd10; in_b = 32'd3;
        #1;
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);                     // EXEC of second op
        exp_count = exp_count + 32'd1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("b2b_op_count", op_count, exp_count);
        check("b2b_exec_out_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_exec_alu_op", {28'd0, alu_op}, 32'b0110);
        check("b2b_exec_alu_a", alu_a, 32'd10);
        @(negedge clk);                     // DONE of second op
        check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_result", out_result, 32'd7);
        $display("op b2b sub 10-3 -> result=0x%08h op_count=%0d", out_result, op_count);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_count = exp_count + 32'd1;
        check("b2b_drain_count", op_count, exp_count);
        check("b2b_drain_valid", {31'd0, out_valid}, 32'd0);

        // Reset while an operation is in EXEC.
        in_valid = 1'b1; in_aluop = 2'b00; in_funct = 6'd0;
        in_a = 32'd1; in_b = 32'd1;
        @(negedge clk);                     // EXEC
        in_valid = 1'b0;
        check("rst_mid_exec_alu_op", {28'd0, alu_op}, 32'b0010);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_mid_alu_a", alu_a, 32'd0);
        check("rst_mid_out_result", out_result, 32'd0);
        check("rst_mid_op_count", op_count, 32'd0);
        rst = 1'b0;
        exp_count = 32'd0;
        #1;
        check("rst_mid_in_ready_after", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        $display("op reset-mid-exec -> out_valid=%0b op_count=%0d", out_valid, op_count);

        // Operation after the mid-op reset counts from zero again.
        run_vec(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential control front-end for the 32-bit combinational ALU: accepts an operation request (main-control ALUOp class, R-type funct field, two operands) over a valid/ready handshake, decodes it to the 4-bit textbook ALU opcode, holds operands and opcode stable on the ALU inputs for one evaluation cycle, and captures Result/Zero into an output register offered downstream over a second valid/ready handshake. It is the initiator side of the ALU interface and sits between the decode stage and writeback/branch logic of the multi-cycle core.

## Interface
- WIDTH, 32, operand/result width (must match the ALU)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when in_valid & in_ready
- in_aluop  in  2  main-control class: 00 load/store, 01 branch, 10 R-type, 11 reserved
- in_funct  in  6  instruction funct field (used only when in_aluop=10)
- in_a, in_b  in  WIDTH  operands (rs, rt)
- alu_a, alu_b  out  WIDTH  to ALU A/B
- alu_op  out  4  to ALU Op
- alu_result  in  WIDTH  from ALU Result
- alu_zero  in  1  from ALU Zero
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_result  out  WIDTH  captured result
- out_zero  out  1  captured zero flag
- out_illegal  out  1  request had an undecodable ALUOp/funct
- op_count  out  32  completed (output-handshaked) operations, wraps 2^32-1 -> 0

## Operation
- States: IDLE, EXEC, DONE. Reset -> IDLE.
- Decode (on acceptance, registered): aluop 00 -> 0010 (add); 01 -> 0110 (sub); 10 with funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000 (and), 100101 -> 0001 (or), 101010 -> 0111 (slt), 100111 -> 1100 (nor); any other funct, or aluop 11 -> illegal, alu_op=0010.
- IDLE: in_ready=1; on handshake latch in_a/in_b into alu_a/alu_b, decoded op into alu_op, illegal flag internally; go EXEC.
- EXEC: alu_a/alu_b/alu_op held stable the whole cycle; at end of cycle capture out_result=alu_result, out_zero=alu_zero, out_illegal=flag; go DONE. If illegal: out_result=0, out_zero=0, out_illegal=1 (ALU output ignored).
- DONE: out_valid=1; out_result/out_zero/out_illegal held stable until out_ready. On out_ready: op_count+1 (illegal ops also counted); if in_valid also high, accept the new request same cycle (in_ready=1) and go EXEC; else go IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready), forced 0 while rst=1.
- Outside EXEC and DONE, alu_a=0, alu_b=0, alu_op=0000 (deterministic idle bus). Inputs in_* are ignored when no handshake occurs.

## Timing
- Reset values (cycle after rst sampled high): state IDLE, in_ready=0 while rst high then 1, alu_a=alu_b=0, alu_op=0000, out_valid=0, out_result=0, out_zero=0, out_illegal=0, op_count=0.
- Latency: handshake at edge N -> EXEC during cycle N+1 -> out_valid=1 from cycle N+2.
- Throughput with out_ready held 1 and in_valid held 1: one result every 2 cycles.
- out_valid never drops without an out_ready handshake (except reset).
- Reset mid-operation (EXEC or DONE): in-flight op discarded, op_count not incremented, all outputs to reset values next cycle.
- Simultaneous DONE handshake and new request: both occur same edge; out_valid=0 during the following EXEC cycle.
- All outputs registered except in_ready (combinational from state, out_ready, rst).

## Test plan
- Add: aluop=10, funct=100000, a=5, b=7 -> alu_op=0010 in EXEC, out_result=12, out_zero=0, out_valid exactly 2 cycles after handshake.
- Branch compare: aluop=01, a=b=0x1234_5678 -> alu_op=0110, out_result=0, out_zero=1.
- SLT signed: funct=101010, a=0xFFFF_FFFF, b=1 -> alu_op=0111, out_result=1; then a=1, b=0xFFFF_FFFF -> 0.
- Illegal: aluop=10, funct=000000 and aluop=11 -> out_illegal=1, out_result=0, out_zero=0, op_count increments on handshake.
- Backpressure/back-to-back: out_ready=0 for 5 cycles -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same edge, op_count+1, next result 2 cycles later.
- Reset mid-op: assert rst during EXEC -> next cycle out_valid=0, alu_op=0000, op_count unchanged at prior value reset to 0, in_ready=1 after rst deasserts.
